// File: rtl/pc_fetch.sv
// Program-counter register and single-outstanding instruction-fetch sequencer.
// Holds the architectural PC, fetches one word at a time, and advances on execute commit.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_FETCH  | request held on the bus at PCaddress until accepted
// S_WAIT   | request accepted, waiting for the instruction word
// S_EXEC   | instr valid for PCaddress, waiting for commit from execute
// S_HALTED | stopped by halt or misaligned target, only reset leaves
module pc_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] PCnext,
  input  logic        PCupdate,
  input  logic        Halt,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        ireq_ready,
  input  logic        iresp_valid,
  input  logic [31:0] iresp_data,
  output logic [63:0] PCaddress,
  output logic [63:0] PCincre,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        halted,
  output logic        misalign,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_WAIT   = 2'd1,
    S_EXEC   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [63:0] pc_q, pc_nxt;
  logic [31:0] instr_q, instr_nxt;
  logic        misalign_q, misalign_nxt;
  logic [31:0] stall_q, stall_nxt;
  logic        stall_now;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      misalign_q <= 1'b0;
      stall_q    <= 32'd0;
    end else begin
      state      <= state_nxt;
      pc_q       <= pc_nxt;
      instr_q    <= instr_nxt;
      misalign_q <= misalign_nxt;
      stall_q    <= stall_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc_q;
    instr_nxt    = instr_q;
    misalign_nxt = misalign_q;
    stall_now    = 1'b0;
    case (state)
      S_FETCH: begin
        if (ireq_ready) state_nxt = S_WAIT;
        else            stall_now = 1'b1;
      end
      S_WAIT: begin
        if (iresp_valid) begin
          instr_nxt = iresp_data;
          state_nxt = S_EXEC;
        end else begin
          stall_now = 1'b1;
        end
      end
      S_EXEC: begin
        if (PCupdate) begin
          pc_nxt = PCnext;
          if (Halt) begin
            state_nxt = S_HALTED;
          end else if (PCnext[1:0] != 2'b00) begin
            misalign_nxt = 1'b1;
            state_nxt    = S_HALTED;
          end else begin
            state_nxt = S_FETCH;
          end
        end
      end
      default: state_nxt = S_HALTED;
    endcase
    // saturate rather than wrap so long stalls never read as short ones
    stall_nxt = (stall_now && stall_q != 32'hFFFF_FFFF) ? stall_q + 32'd1 : stall_q;
  end

  assign ireq_valid   = (state == S_FETCH);
  assign ireq_addr    = pc_q;
  assign PCaddress    = pc_q;
  assign PCincre      = pc_q + 64'd4;
  assign instr        = instr_q;
  assign instr_valid  = (state == S_EXEC);
  assign halted       = (state == S_HALTED);
  assign misalign     = misalign_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: reset, commits, stalls, wrap, halt, misalign, reset mid-fetch.
module tb_pc_fetch;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        reset;
  logic [63:0] PCnext;
  logic        PCupdate;
  logic        Halt;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        ireq_ready;
  logic        iresp_valid;
  logic [31:0] iresp_data;
  logic [63:0] PCaddress;
  logic [63:0] PCincre;
  logic [31:0] instr;
  logic        instr_valid;
  logic        halted;
  logic        misalign;
  logic [31:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;
  int req_cnt  = 0;
  int req_before;

  pc_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .PCnext(PCnext), .PCupdate(PCupdate), .Halt(Halt),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_ready(ireq_ready),
    .iresp_valid(iresp_valid), .iresp_data(iresp_data), .PCaddress(PCaddress),
    .PCincre(PCincre), .instr(instr), .instr_valid(instr_valid), .halted(halted),
    .misalign(misalign), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (!reset && ireq_valid && ireq_ready) req_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // entered at a negedge in FETCH; leaves at a negedge in EXEC
  task automatic fetch_once(input logic [63:0] addr, input logic [31:0] word);
    check("fetch_req", {63'd0, ireq_valid}, 64'd1);
    check("fetch_addr", ireq_addr, addr);
    ireq_ready = 1'b1;
    @(negedge clk);
    ireq_ready = 1'b0;
    check("wait_noreq", {63'd0, ireq_valid}, 64'd0);
    iresp_valid = 1'b1;
    iresp_data  = word;
    @(negedge clk);
    iresp_valid = 1'b0;
    check("exec_valid", {63'd0, instr_valid}, 64'd1);
    check("exec_instr", {32'd0, instr}, {32'd0, word});
  endtask

  task automatic commit(input logic [63:0] nxt, input logic hlt);
    PCupdate = 1'b1;
    PCnext   = nxt;
    Halt     = hlt;
    @(negedge clk);
    PCupdate = 1'b0;
    Halt     = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; PCnext = '0; PCupdate = 0; Halt = 0;
    ireq_ready = 0; iresp_valid = 0; iresp_data = '0;
    #3;
    check("rst_pc", PCaddress, RST_PC);
    check("rst_instr", {32'd0, instr}, 64'd0);
    check("rst_ivalid", {63'd0, instr_valid}, 64'd0);
    check("rst_halted", {63'd0, halted}, 64'd0);
    check("rst_misalign", {63'd0, misalign}, 64'd0);
    check("rst_stall", {32'd0, stall_cycles}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // reset and first fetch
    fetch_once(64'h8000_0000, 32'h0000_0013);
    check("first_incre", PCincre, 64'h8000_0004);

    // sequential and branch commits
    commit(64'h8000_0004, 1'b0);
    fetch_once(64'h8000_0004, 32'h0040_0093);
    commit(64'h8000_0100, 1'b0);
    fetch_once(64'h8000_0100, 32'h0000_0063);
    check("req_count", req_cnt, 64'd3);
    check("no_stall_yet", {32'd0, stall_cycles}, 64'd0);

    // PCincre wraps at the top of the address space
    commit(64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    check("wrap_addr", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_incre", PCincre, 64'd0);
    fetch_once(64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0013);
    commit(64'h8000_0040, 1'b0);

    // bus stalls: 3 cycles not ready, then 2 cycles without response
    for (int i = 0; i < 3; i++) begin
      check("stall_f_addr", ireq_addr, 64'h8000_0040);
      check("stall_f_req", {63'd0, ireq_valid}, 64'd1);
      @(negedge clk);
    end
    ireq_ready = 1'b1;
    @(negedge clk);
    ireq_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("stall_w_iv", {63'd0, instr_valid}, 64'd0);
      check("stall_w_pc", PCaddress, 64'h8000_0040);
      @(negedge clk);
    end
    iresp_valid = 1'b1;
    iresp_data  = 32'h0000_1117;
    @(negedge clk);
    iresp_valid = 1'b0;
    check("stall_count", {32'd0, stall_cycles}, 64'd5);
    check("stall_instr", {32'd0, instr}, 64'h0000_1117);

    // reset while waiting for a response
    commit(64'h8000_0040, 1'b0);
    ireq_ready = 1'b1;
    @(negedge clk);
    ireq_ready = 1'b0;
    check("midwait_pc", PCaddress, 64'h8000_0040);
    reset = 1'b1;
    #1;
    check("midwait_rst_pc", PCaddress, RST_PC);
    check("midwait_rst_stall", {32'd0, stall_cycles}, 64'd0);
    check("midwait_rst_iv", {63'd0, instr_valid}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    check("restart_addr", ireq_addr, 64'h8000_0000);

    // a response that is early (during FETCH) must be ignored
    ireq_ready  = 1'b1;
    iresp_valid = 1'b1;
    iresp_data  = 32'h0000_DEAD;
    @(negedge clk);
    ireq_ready = 1'b0;
    iresp_data = 32'h0000_BEEF;
    check("early_resp_iv", {63'd0, instr_valid}, 64'd0);
    @(negedge clk);
    iresp_valid = 1'b0;
    check("early_resp_instr", {32'd0, instr}, 64'h0000_BEEF);

    // misaligned commit target
    commit(64'h8000_0002, 1'b0);
    check("mis_pc", PCaddress, 64'h8000_0002);
    check("mis_flag", {63'd0, misalign}, 64'd1);
    check("mis_halted", {63'd0, halted}, 64'd1);
    check("mis_noreq", {63'd0, ireq_valid}, 64'd0);

    // halt, then 20 cycles of ignored commits and bus activity
    do_reset();
    fetch_once(64'h8000_0000, 32'h0000_0013);
    commit(64'h8000_0004, 1'b0);
    fetch_once(64'h8000_0004, 32'h0010_0073);
    commit(64'h8000_0004, 1'b1);
    check("halt_flag", {63'd0, halted}, 64'd1);
    check("halt_nomis", {63'd0, misalign}, 64'd0);
    check("halt_pc", PCaddress, 64'h8000_0004);
    req_before  = req_cnt;
    ireq_ready  = 1'b1;
    iresp_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      PCupdate = 1'b1;
      PCnext   = 64'h1234_5678;
      check("halt_noreq", {63'd0, ireq_valid}, 64'd0);
      @(negedge clk);
    end
    PCupdate = 1'b0; ireq_ready = 1'b0; iresp_valid = 1'b0;
    check("halt_req_count", req_cnt, req_before);
    check("halt_pc_held", PCaddress, 64'h8000_0004);
    check("halt_still", {63'd0, halted}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
